serial_bcd_host: RTL and testbench
==================================

Name: serial_bcd_host

Overview:
- Host-side partner of the serial BCD ALU.
- Serializes one operand frame {op, B, A} (4-digit BCD operands) onto the ALU's serial input with an enable strobe.
- Then deserializes the 5-digit BCD result that the ALU shifts back while the enable is low.
- Sits between a parallel controller/register bank and the serial ALU, so a bench or CPU can issue parallel BCD operations.

Parameters:
- RESULT_LAT, 1, clocks from the first cycle with ser_en low to the first sampled result bit (1..7).
- FRAME_W, 33, operand frame length in bits (fixed; not intended to be overridden).
- RES_W, 20, result length in bits (5 BCD digits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one operation; sampled only in IDLE.
- a  in  16  operand A, 4 packed BCD digits, A[15:12] most significant.
- b  in  16  operand B, same packing.
- sub  in  1  operation select: 0 = add, 1 = subtract; sent as frame bit 32.
- ser_out  out  1  serial data to the ALU "in" pin.
- ser_en  out  1  drives the ALU "en" pin; high exactly while frame bits are valid.
- ser_in  in  1  serial result from the ALU "result" pin.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when result is updated.
- result  out  20  last received BCD result, held until next done.
- err  out  1  sticky flag: last start rejected for an illegal digit; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; ser_out=0, ser_en=0, busy=0, done=0, err=0, result=0, all counters=0. Takes effect immediately, including mid-frame or mid-receive. No partial result is ever published.
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE:
  - On start=1, check all eight digits of a and b for values <=9.
  - Any digit >9: set err=1, stay IDLE, ser_en stays 0.
  - Otherwise: clear err, latch frame = {sub, b, a} into a 33-bit shift register, go to SEND.
- SEND:
  - 33 consecutive cycles with ser_en=1.
  - ser_out = frame MSB first: sub, then b[15..0], then a[15..0].
  - The first bit is presented in the first SEND cycle, registered output, one clock after start was sampled.
  - Bit counter runs 0..32; after bit 32, ser_en drops to 0 and the state goes to WAIT.
- WAIT:
  - ser_en=0, ser_out=0 for RESULT_LAT cycles, counting the first ser_en-low cycle.
  - Then go to RECV.
- RECV:
  - Sample ser_in on 20 consecutive rising edges; shift left into the receive register (MSB first).
  - ser_en is held 0 throughout.
  - After the 20th bit, copy the receive register to result and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done falls.
- start while busy=1: ignored, with no queueing and no effect on err.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE. a, b and sub are re-sampled at that point.
- Changes to a, b or sub after start is accepted do not affect the frame in flight.
- Total latency, start sample to done: 1 + 33 + RESULT_LAT + 20 cycles, i.e. 55 with default RESULT_LAT = 1.
- result is never partially updated; it holds its value through reset-free idle periods.

Test Plan:
- Frame check: rst_n low 2 cycles; a=16'h1234, b=16'h5678, sub=0, start 1 cycle -> ser_en high exactly 33 cycles. ser_out sequence is 0, 0101 0110 0111 1000, 0001 0010 0011 0100.
- Receive: bench responder drives 20'h06912 MSB first starting RESULT_LAT cycles after ser_en falls -> done pulses once at cycle 55; result=20'h06912; busy=0 the next cycle.
- Subtract and full-range values: a=16'h9999, b=16'h0001, sub=1 -> first frame bit 1. Responder returns 20'h09998 -> result=20'h09998.
- Illegal digit: a=16'h12A4, start -> err=1, ser_en never asserts, busy stays 0. Then a legal start -> err=0 and the frame is sent.
- Start while busy: second start pulse issued at cycle 10 of SEND -> frame unchanged, exactly one done, no second frame.
- Reset mid-operation: rst_n low at SEND bit 15 -> ser_en=0 and busy=0 immediately; result retains 0. A fresh start after release produces a full 33-bit frame. Repeat with reset mid-RECV, and repeat with RESULT_LAT=3.

Source files
------------

// File: rtl/serial_bcd_host.sv
// Host side of the serial BCD ALU: shifts out one {op, B, A} frame under ser_en,
// then collects the 5-digit BCD result the ALU shifts back and publishes it whole.
module serial_bcd_host #(
    parameter int RESULT_LAT = 1,
    parameter int FRAME_W    = 33,
    parameter int RES_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             sub,
    output logic             ser_out,
    output logic             ser_en,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);
    localparam logic [5:0] LAT_LAST = 6'(RESULT_LAT - 1);
    localparam logic [5:0] RX_LAST  = 6'(RES_W - 1);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [RES_W-1:0]   rx_q, rx_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_en_q, ser_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    function automatic logic digits_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        result_d  = result_q;
        err_d     = err_q;
        ser_out_d = 1'b0;
        ser_en_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (digits_ok(a) && digits_ok(b)) begin
                        err_d     = 1'b0;
                        frame_d   = {sub, b, a};
                        ser_out_d = sub;
                        ser_en_d  = 1'b1;
                        cnt_d     = 6'd0;
                        state_d   = S_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // ser_out_q already shows frame_q MSB; queue up the next bit.
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = 6'd0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d     = cnt_q + 6'd1;
                    frame_d   = frame_q << 1;
                    ser_out_d = frame_q[FRAME_W-2];
                    ser_en_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = S_RECV;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_RECV: begin
                rx_d = {rx_q[RES_W-2:0], ser_in};
                if (cnt_q == RX_LAST) begin
                    result_d = rx_d;
                    done_d   = 1'b1;
                    cnt_d    = 6'd0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            cnt_q     <= '0;
            rx_q      <= '0;
            result_q  <= '0;
            ser_out_q <= 1'b0;
            ser_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            result_q  <= result_d;
            ser_out_q <= ser_out_d;
            ser_en_q  <= ser_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_en    = ser_en_q;
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_bcd_host.sv
// Bench for serial_bcd_host: two instances (RESULT_LAT 1 and 3) checked every cycle
// against a timeline model of one operation, plus directed literal checks.
module tb_serial_bcd_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic [19:0] next_resp = '0;

    logic [1:0]  ser_in_w = '0;
    logic [1:0]  ser_out_w, ser_en_w, busy_w, done_w, err_w;
    logic [19:0] result_w [2];
    logic [2:0]  dbg_w [2];

    int n_checks = 0;
    int n_fail   = 0;

    serial_bcd_host #(.RESULT_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
        .ser_out(ser_out_w[0]), .ser_en(ser_en_w[0]), .ser_in(ser_in_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]), .err(err_w[0]),
        .dbg_state(dbg_w[0])
    );

    serial_bcd_host #(.RESULT_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
        .ser_out(ser_out_w[1]), .ser_en(ser_en_w[1]), .ser_in(ser_in_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]), .err(err_w[1]),
        .dbg_state(dbg_w[1])
    );

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bcd_ok(input logic [15:0] v);
        int x;
        x = int'(v);
        for (int i = 0; i < 4; i++) begin
            if (x % 16 > 9) return 1'b0;
            x = x / 16;
        end
        return 1'b1;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Model: t_m = cycles since the accepted start (0 = idle). Frame bit i is on
    // the wire at t=i+1, the response word at t=35+LAT-1.., done at t=54+LAT.
    int          t_m   [2] = '{0, 0};
    logic [32:0] frm_m [2] = '{33'd0, 33'd0};
    logic [19:0] res_m [2] = '{20'd0, 20'd0};
    logic        err_m [2] = '{1'b0, 1'b0};
    logic [19:0] exp_q [2][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                t_m[k] = 0;
                err_m[k] = 1'b0;
                res_m[k] = '0;
                exp_q[k].delete();
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (t_m[k] == 0) begin
                    if (start) begin
                        if (bcd_ok(a) && bcd_ok(b)) begin
                            t_m[k] = 1;
                            frm_m[k] = {sub, b, a};
                            exp_q[k].push_back(next_resp);
                            err_m[k] = 1'b0;
                        end else begin
                            err_m[k] = 1'b1;
                        end
                    end
                end else if (t_m[k] == 54 + lat_of(k)) begin
                    t_m[k] = 0;
                end else begin
                    t_m[k] = t_m[k] + 1;
                    if (t_m[k] == 54 + lat_of(k)) res_m[k] = exp_q[k].pop_front();
                end
            end
        end
    end

    // ALU stand-in: the response word during the receive window, noise elsewhere.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int r0;
            logic [19:0] w;
            r0 = 34 + lat_of(k);
            if (t_m[k] >= r0 && t_m[k] < r0 + 20 && exp_q[k].size() > 0) begin
                w = exp_q[k][0];
                ser_in_w[k] = w[19 - (t_m[k] - r0)];
            end else begin
                ser_in_w[k] = 1'($urandom_range(0, 1));
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            logic en_e, so_e;
            int t;
            t = t_m[k];
            en_e = (t >= 1 && t <= 33);
            so_e = en_e ? frm_m[k][33 - t] : 1'b0;
            chk($sformatf("ser_en[%0d]", k), 33'(ser_en_w[k]), 33'(en_e));
            chk($sformatf("ser_out[%0d]", k), 33'(ser_out_w[k]), 33'(so_e));
            chk($sformatf("busy[%0d]", k), 33'(busy_w[k]), 33'(t != 0));
            chk($sformatf("done[%0d]", k), 33'(done_w[k]), 33'(t == 54 + lat_of(k)));
            chk($sformatf("result[%0d]", k), 33'(result_w[k]), 33'(res_m[k]));
            chk($sformatf("err[%0d]", k), 33'(err_w[k]), 33'(err_m[k]));
        end
    end

    // One start pulse, then watch instance 0 for n cycles.
    task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input logic s,
                          input logic [19:0] resp, input int n,
                          output int en_cnt, output int done_at, output int done_cnt,
                          output logic [32:0] bits, output logic first_bit,
                          output logic busy_after);
        en_cnt = 0; done_at = 0; done_cnt = 0; bits = '0; first_bit = 1'b0; busy_after = 1'b1;
        @(negedge clk);
        a = aa; b = bb; sub = s; next_resp = resp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            #2;
            if (c == 1) first_bit = ser_out_w[0];
            if (ser_en_w[0]) begin
                en_cnt++;
                bits = {bits[31:0], ser_out_w[0]};
            end
            if (done_w[0]) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (done_at != 0 && c == done_at + 1) busy_after = busy_w[0];
            @(negedge clk);
        end
    endtask

    task automatic reset_at(input int at_cycle);
        @(negedge clk);
        a = 16'h4321; b = 16'h8765; sub = 1'b1; next_resp = 20'h13579; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at_cycle - 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ser_en[%0d]", k), 33'(ser_en_w[k]), 33'd0);
            chk($sformatf("rst_busy[%0d]", k), 33'(busy_w[k]), 33'd0);
            chk($sformatf("rst_result[%0d]", k), 33'(result_w[k]), 33'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        int en_cnt, done_at, done_cnt;
        logic [32:0] bits;
        logic fb, ba;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 33'(busy_w[0]), 33'd0);
        chk("reset_result", 33'(result_w[0]), 33'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 1'b0, 20'h06912, 70, en_cnt, done_at, done_cnt, bits, fb, ba);
        chk("frame_len", 33'(en_cnt), 33'd33);
        chk("frame_bits", bits, {1'b0, 16'h5678, 16'h1234});
        chk("done_cycle", 33'(done_at), 33'd55);
        chk("done_count", 33'(done_cnt), 33'd1);
        chk("busy_after_done", 33'(ba), 33'd0);
        chk("result_add", 33'(result_w[0]), 33'(20'h06912));
        chk("result_add_lat3", 33'(result_w[1]), 33'(20'h06912));

        run_op(16'h9999, 16'h0001, 1'b1, 20'h09998, 70, en_cnt, done_at, done_cnt, bits, fb, ba);
        chk("sub_first_bit", 33'(fb), 33'd1);
        chk("sub_frame_bits", bits, {1'b1, 16'h0001, 16'h9999});
        chk("result_sub", 33'(result_w[0]), 33'(20'h09998));

        @(negedge clk);
        a = 16'h12A4; b = 16'h0000; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("illegal_err", 33'(err_w[0]), 33'd1);
        chk("illegal_busy", 33'(busy_w[0]), 33'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            chk("illegal_no_en", 33'(ser_en_w[0]), 33'd0);
        end
        run_op(16'h0042, 16'h0007, 1'b0, 20'h00049, 70, en_cnt, done_at, done_cnt, bits, fb, ba);
        chk("legal_err_clear", 33'(err_w[0]), 33'd0);
        chk("legal_frame_len", 33'(en_cnt), 33'd33);

        // second start arrives during SEND bit 10 and must be dropped
        @(negedge clk);
        a = 16'h5555; b = 16'h2222; sub = 1'b0; next_resp = 20'h07777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        a = 16'h1111; b = 16'h1111; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            #2;
            if (ser_en_w[0]) en_cnt++;
            if (done_w[0]) done_cnt++;
            @(negedge clk);
        end
        chk("busy_start_en_rest", 33'(en_cnt), 33'd22);
        chk("busy_start_one_done", 33'(done_cnt), 33'd1);
        chk("busy_start_result", 33'(result_w[0]), 33'(20'h07777));

        reset_at(16);
        run_op(16'h0808, 16'h0909, 1'b0, 20'h01717, 70, en_cnt, done_at, done_cnt, bits, fb, ba);
        chk("post_rst_frame_len", 33'(en_cnt), 33'd33);
        chk("post_rst_frame_bits", bits, {1'b0, 16'h0909, 16'h0808});
        reset_at(45);
        run_op(16'h3000, 16'h0003, 1'b1, 20'h02997, 70, en_cnt, done_at, done_cnt, bits, fb, ba);
        chk("post_rst2_result", 33'(result_w[1]), 33'(20'h02997));

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 3) == 0);
            a = rand_bcd();
            b = rand_bcd();
            sub = 1'($urandom_range(0, 1));
            next_resp = 20'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (80) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
